// File: rtl/uart_rx_core_if.sv
// AXI-Stream word output bundle of the UART receiver.
// The receiver drives it as master; the consumer is the slave.
interface uart_rx_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver with 8x oversampling, delivering words on AXI-Stream.
// Reports busy, overrun and framing status.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_rx_core_if.master output_axis,
    input  logic           rxd,
    input  logic [15:0]    prescale,
    output logic           busy,
    output logic           overrun_error,
    output logic           frame_error
);
    localparam int CW = 19;
    localparam int IW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_sync1;
    logic                  r_sync2;
    logic                  r_rxd_prev;
    logic [15:0]           r_p;
    logic [15:0]           w_p_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [IW-1:0]         r_bit;
    logic [IW-1:0]         w_bit_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_overrun;
    logic                  r_frame;
    logic                  w_rxd_s;
    logic                  w_fall;
    logic                  w_tick;
    logic                  w_word;
    logic                  w_ferr;
    logic                  w_xfer;
    logic [CW-1:0]         w_half;
    logic [CW-1:0]         w_full;

    assign w_rxd_s = r_sync2;
    assign w_fall  = r_rxd_prev & ~w_rxd_s;
    assign w_tick  = (r_cnt == CW'(1));
    // Half a bit uses the live prescale; whole bits use the latched copy.
    assign w_half  = {1'b0, prescale, 2'b00};
    assign w_full  = {r_p, 3'b000};
    assign w_xfer  = r_tvalid & output_axis.tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rxd_prev <= 1'b1;
        end else begin
            r_sync1    <= rxd;
            r_sync2    <= r_sync1;
            r_rxd_prev <= r_sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_p     <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_word      = 1'b0;
        w_ferr      = 1'b0;
        if (r_state != S_IDLE && !w_tick) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
        unique case (r_state)
            S_IDLE: begin
                if (w_fall && prescale != 16'd0) begin
                    w_p_nxt     = prescale;
                    w_cnt_nxt   = w_half;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (w_rxd_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = w_full;
                        w_bit_nxt   = '0;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_shift_nxt = {w_rxd_s, r_shift[DATA_WIDTH-1:1]};
                    w_cnt_nxt   = w_full;
                    if (r_bit == IW'(DATA_WIDTH - 1)) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + IW'(1);
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_word      = w_rxd_s;
                    w_ferr      = ~w_rxd_s;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A new word wins over a same-cycle transfer, so tvalid stays high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tdata   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
            r_frame   <= 1'b0;
        end else begin
            r_tvalid  <= w_word | (r_tvalid & ~w_xfer);
            r_overrun <= w_word & r_tvalid & ~output_axis.tready;
            r_frame   <= w_ferr;
            if (w_word) begin
                r_tdata <= r_shift;
            end
        end
    end

    assign output_axis.tdata  = r_tdata;
    assign output_axis.tvalid = r_tvalid;
    assign busy               = (r_state != S_IDLE);
    assign overrun_error      = r_overrun;
    assign frame_error        = r_frame;
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: serial frames in, words checked
// against a queue of expected bytes as they are handed over.
module tb_uart_rx_core;
    localparam int DW = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rxd = 1'b1;
    logic [15:0] prescale = 16'd2;
    logic        busy;
    logic        overrun_error;
    logic        frame_error;

    uart_rx_core_if #(.DATA_WIDTH(DW)) axis ();

    uart_rx_core #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .output_axis  (axis),
        .rxd          (rxd),
        .prescale     (prescale),
        .busy         (busy),
        .overrun_error(overrun_error),
        .frame_error  (frame_error)
    );

    always #5 clk = ~clk;

    logic [7:0] sb[$];
    logic [7:0] exp_b;
    int n_checks = 0;
    int n_errors = 0;
    int ovr_cnt = 0;
    int ferr_cnt = 0;
    int rx_cnt = 0;
    int cyc = 0;
    int busy_rise = 0;
    int tv_rise = 0;
    logic prev_busy = 1'b0;
    logic prev_tv = 1'b0;
    logic prev_stall = 1'b0;
    logic prev_ferr = 1'b0;
    logic prev_ovr = 1'b0;
    logic [DW-1:0] prev_data = '0;
    bit tog_en = 1'b0;

    initial axis.tready = 1'b0;

    always @(posedge clk) begin
        if (tog_en) begin
            #1 axis.tready = ~axis.tready;
        end
    end

    // Monitor: samples on the falling edge, between driver updates.
    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (busy && !prev_busy) busy_rise = cyc;
            if (axis.tvalid && !prev_tv) tv_rise = cyc;
            if (overrun_error) begin
                ovr_cnt++;
                n_checks++;
                if (prev_ovr) begin
                    n_errors++;
                    $display("FAIL ovr_pulse_width got=2+ cycles exp=1");
                end
            end
            if (frame_error) begin
                ferr_cnt++;
                n_checks++;
                if (prev_ferr) begin
                    n_errors++;
                    $display("FAIL ferr_pulse_width got=2+ cycles exp=1");
                end
            end
            if (prev_stall && axis.tvalid) begin
                n_checks++;
                if (axis.tdata !== prev_data && !overrun_error) begin
                    n_errors++;
                    $display("FAIL stall_stable got=%h exp=%h", axis.tdata, prev_data);
                end
            end
            if (axis.tvalid && axis.tready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_word got=%h exp=none", axis.tdata);
                end else begin
                    exp_b = sb.pop_front();
                    rx_cnt++;
                    if (axis.tdata !== exp_b) begin
                        n_errors++;
                        $display("FAIL rx_data got=%h exp=%h", axis.tdata, exp_b);
                    end
                end
            end
        end
        prev_busy  = busy;
        prev_tv    = axis.tvalid;
        prev_stall = axis.tvalid & ~axis.tready;
        prev_ferr  = frame_error;
        prev_ovr   = overrun_error;
        prev_data  = axis.tdata;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit good, input int p);
        logic [9:0] bits;
        prescale = 16'(p);
        bits = {good, d, 1'b0};
        if (good) sb.push_back(d);
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            wait_cyc(8 * p);
        end
        rxd = 1'b1;
    endtask

    task automatic test_reset();
        wait_cyc(3);
        n_checks++;
        if (axis.tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_tvalid got=%b exp=0", axis.tvalid);
        end
        n_checks++;
        if (axis.tdata !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_tdata got=%h exp=00", axis.tdata);
        end
        n_checks++;
        if ({busy, overrun_error, frame_error} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_status got=%b exp=000", {busy, overrun_error, frame_error});
        end
        rst_n = 1'b1;
        wait_cyc(5);
        n_checks++;
        if (busy !== 1'b0 || axis.tvalid !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_reset got=%b%b exp=00", busy, axis.tvalid);
        end
    endtask

    task automatic test_basic();
        int r0;
        int f0;
        r0 = rx_cnt;
        f0 = ferr_cnt;
        axis.tready = 1'b1;
        send_frame(8'hA5, 1'b1, 2);
        wait_cyc(5);
        n_checks++;
        if (rx_cnt - r0 != 1 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL basic_count got=%0d exp=1", rx_cnt - r0);
        end
        n_checks++;
        if (ferr_cnt != f0) begin
            n_errors++;
            $display("FAIL basic_ferr got=%0d exp=0", ferr_cnt - f0);
        end
        // busy rises at T0+1, tvalid at stop sample + 1
        n_checks++;
        if (tv_rise - busy_rise != 4 * 2 + 8 * 2 * (DW + 1)) begin
            n_errors++;
            $display("FAIL basic_latency got=%0d exp=%0d", tv_rise - busy_rise, 4 * 2 + 8 * 2 * (DW + 1));
        end
    endtask

    task automatic test_frame_error();
        int r0;
        int f0;
        r0 = rx_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 2);
        wait_cyc(3);
        n_checks++;
        if (ferr_cnt - f0 != 1) begin
            n_errors++;
            $display("FAIL ferr_count got=%0d exp=1", ferr_cnt - f0);
        end
        n_checks++;
        if (axis.tvalid !== 1'b0 || rx_cnt != r0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ferr_no_word got=%b/%0d exp=0/0", axis.tvalid, rx_cnt - r0);
        end
        wait_cyc(20);
        send_frame(8'h5A, 1'b1, 2);
        wait_cyc(5);
        n_checks++;
        if (rx_cnt - r0 != 1 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL ferr_recover got=%0d exp=1", rx_cnt - r0);
        end
    endtask

    task automatic test_overrun();
        int r0;
        int o0;
        r0 = rx_cnt;
        o0 = ovr_cnt;
        axis.tready = 1'b0;
        send_frame(8'h11, 1'b1, 2);
        wait_cyc(2);
        n_checks++;
        if (axis.tvalid !== 1'b1 || axis.tdata !== 8'h11) begin
            n_errors++;
            $display("FAIL ovr_first got=%b/%h exp=1/11", axis.tvalid, axis.tdata);
        end
        // 0x11 is never taken: the next word overwrites it
        void'(sb.pop_front());
        send_frame(8'h22, 1'b1, 2);
        wait_cyc(2);
        n_checks++;
        if (ovr_cnt - o0 != 1) begin
            n_errors++;
            $display("FAIL ovr_count got=%0d exp=1", ovr_cnt - o0);
        end
        n_checks++;
        if (axis.tdata !== 8'h22) begin
            n_errors++;
            $display("FAIL ovr_data got=%h exp=22", axis.tdata);
        end
        axis.tready = 1'b1;
        wait_cyc(5);
        n_checks++;
        if (rx_cnt - r0 != 1 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL ovr_drain got=%0d exp=1", rx_cnt - r0);
        end
    endtask

    task automatic test_glitch();
        int r0;
        int f0;
        int b0;
        r0 = rx_cnt;
        f0 = ferr_cnt;
        b0 = busy_rise;
        prescale = 16'd2;
        wait_cyc(4);
        rxd = 1'b0;
        wait_cyc(4);
        rxd = 1'b1;
        wait_cyc(30);
        n_checks++;
        if (busy_rise == b0) begin
            n_errors++;
            $display("FAIL glitch_start got=no busy exp=busy pulse");
        end
        n_checks++;
        if (busy !== 1'b0 || rx_cnt != r0 || ferr_cnt != f0) begin
            n_errors++;
            $display("FAIL glitch_quiet got=%b/%0d/%0d exp=0/0/0", busy, rx_cnt - r0, ferr_cnt - f0);
        end
        send_frame(8'hFF, 1'b1, 2);
        wait_cyc(5);
        n_checks++;
        if (rx_cnt - r0 != 1 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL glitch_next got=%0d exp=1", rx_cnt - r0);
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] bits;
        int r0;
        int f0;
        r0 = rx_cnt;
        f0 = ferr_cnt;
        prescale = 16'd4;
        bits = {1'b1, 8'h81, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rxd = bits[i];
            if (i == 4) begin
                wait_cyc(16);
                n_checks++;
                if (busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL mid_busy got=%b exp=1", busy);
                end
                rst_n = 1'b0;
                #1;
                n_checks++;
                if (busy !== 1'b0 || axis.tvalid !== 1'b0 || axis.tdata !== 8'h00) begin
                    n_errors++;
                    $display("FAIL mid_reset got=%b/%b/%h exp=0/0/00", busy, axis.tvalid, axis.tdata);
                end
                wait_cyc(16);
            end else begin
                wait_cyc(32);
            end
        end
        rxd = 1'b1;
        wait_cyc(10);
        rst_n = 1'b1;
        wait_cyc(400);
        n_checks++;
        if (axis.tvalid !== 1'b0 || rx_cnt != r0 || ferr_cnt != f0) begin
            n_errors++;
            $display("FAIL mid_idle got=%b/%0d/%0d exp=0/0/0", axis.tvalid, rx_cnt - r0, ferr_cnt - f0);
        end
        send_frame(8'h81, 1'b1, 4);
        wait_cyc(5);
        n_checks++;
        if (rx_cnt - r0 != 1 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL mid_recover got=%0d exp=1", rx_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int r0;
        int o0;
        r0 = rx_cnt;
        o0 = ovr_cnt;
        tog_en = 1'b1;
        send_frame(8'h00, 1'b1, 1);
        send_frame(8'hFF, 1'b1, 1);
        send_frame(8'h55, 1'b1, 1);
        wait_cyc(10);
        tog_en = 1'b0;
        wait_cyc(2);
        axis.tready = 1'b1;
        wait_cyc(5);
        n_checks++;
        if (rx_cnt - r0 != 3 || sb.size() != 0) begin
            n_errors++;
            $display("FAIL b2b_count got=%0d exp=3", rx_cnt - r0);
        end
        n_checks++;
        if (ovr_cnt != o0) begin
            n_errors++;
            $display("FAIL b2b_overrun got=%0d exp=0", ovr_cnt - o0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_frame_error();
        test_overrun();
        test_glitch();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
